// File: rtl/sha_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha_acc_pkg
// Description : Shared constants and FSM state type for the SHA-256
//               accelerator job master.
//               CTRL_ADDR  - accelerator control register address
//               CMD_START  - control word that launches a hash
//               CMD_ACK    - control word that acknowledges a finished hash
//               IDX_DONE   - hash_idx value flagging the completion marker
//               state_t    - job master FSM states
// Revision    : 1.0 - initial release
// ============================================================================
package sha_acc_pkg;

  localparam logic [4:0]  CTRL_ADDR = 5'd16;
  localparam logic [31:0] CMD_START = 32'hFFFF_FFFF;
  localparam logic [31:0] CMD_ACK   = 32'h1111_1111;
  localparam logic [3:0]  IDX_DONE  = 4'd8;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD   = 4'd1,
    ST_NONCE  = 4'd2,
    ST_START  = 4'd3,
    ST_WAIT   = 4'd4,
    ST_ACK    = 4'd5,
    ST_DRAIN  = 4'd6,
    ST_REPORT = 4'd7,
    ST_NEXT   = 4'd8
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sha_job_master_if.sv
`default_nettype none
// ============================================================================
// Module      : sha_job_master_if
// Description : Bus between the job master and one SHA-256 accelerator.
//               avm_chipselect/avm_write - write strobe (1 cycle per write)
//               avm_address              - 0-15 data words, 16 control
//               avm_writedata            - write data
//               hash_idx                 - 0-7 hash word index, 8 = marker
//               hash_data                - hash word / marker value
//               master: job master side, slave: accelerator side.
// Revision    : 1.0 - initial release
// ============================================================================
interface sha_job_master_if;
  logic        avm_chipselect;
  logic        avm_write;
  logic [4:0]  avm_address;
  logic [31:0] avm_writedata;
  logic [3:0]  hash_idx;
  logic [31:0] hash_data;

  modport master (
    output avm_chipselect, avm_write, avm_address, avm_writedata,
    input  hash_idx, hash_data
  );

  modport slave (
    input  avm_chipselect, avm_write, avm_address, avm_writedata,
    output hash_idx, hash_data
  );
endinterface
`default_nettype wire

// File: rtl/sha_job_master_hash_capture.sv
`default_nettype none
// ============================================================================
// Module      : hash_capture
// Description : Index-addressed 8x32 capture register for the hash words the
//               accelerator streams back, plus completion-marker detection.
//               clk, reset     - clock, synchronous active-high reset
//               clear          - empties the register and the seen flag
//               enable         - capture window (job master in WAIT)
//               hash_idx/data  - raw accelerator outputs
//               hash           - captured hash, word i = bits [32i+31:32i]
//               marker_done    - completion marker accepted this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module hash_capture
  import sha_acc_pkg::*;
(
  input  wire          clk,
  input  wire          reset,
  input  wire          clear,
  input  wire          enable,
  input  wire  [3:0]   hash_idx,
  input  wire  [31:0]  hash_data,
  output logic [255:0] hash,
  output logic         marker_done
);

  localparam logic [31:0] c_marker_word = 32'hFFFF_FFFF;

  logic [255:0] r_hash;
  logic         r_seen;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_hash <= '0;
      r_seen <= 1'b0;
    end else if (enable && !hash_idx[3]) begin
      r_hash[{hash_idx[2:0], 5'b00000} +: 32] <= hash_data;
      r_seen <= 1'b1;
    end
  end

  // A marker left over from the previous hash may still be on the bus when
  // the window opens; it only counts once a fresh word has been sampled.
  assign marker_done = enable && r_seen && (hash_idx == IDX_DONE) &&
                       (hash_data == c_marker_word);
  assign hash        = r_hash;

endmodule
`default_nettype wire

// File: rtl/sha_job_master.sv
`default_nettype none
// ============================================================================
// Module      : sha_job_master
// Description : Host-side initiator for the SHA-256 accelerator. Sweeps an
//               inclusive (wrapping) nonce range over one 512-bit block,
//               launches a hash per nonce, captures the result and reports
//               every hash strictly below the target.
//               clk, reset      - clock, synchronous active-high reset
//               job_*           - job offer (valid/ready handshake)
//               acc             - accelerator write bus and hash return
//               res_*           - hit report (valid held until ready)
//               busy            - FSM not idle
//               done            - one-cycle pulse after the last nonce
// Revision    : 1.0 - initial release
// ============================================================================
module sha_job_master
  import sha_acc_pkg::*;
#(
  parameter int NONCE_IDX = 3
) (
  input  wire          clk,
  input  wire          reset,
  input  wire          job_valid,
  output logic         job_ready,
  input  wire  [511:0] job_block,
  input  wire  [31:0]  job_nonce_start,
  input  wire  [31:0]  job_nonce_end,
  input  wire  [255:0] job_target,
  sha_job_master_if.master acc,
  output logic         res_valid,
  input  wire          res_ready,
  output logic [31:0]  res_nonce,
  output logic [255:0] res_hash,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] c_nonce_idx  = 4'(NONCE_IDX);
  localparam logic [4:0] c_nonce_addr = 5'(NONCE_IDX);

  state_t       r_state;
  state_t       w_state_next;
  logic [511:0] r_block;
  logic [255:0] r_target;
  logic [31:0]  r_nonce;
  logic [31:0]  r_nonce_end;
  logic [3:0]   r_word_cnt;
  logic         r_hit;
  logic         r_avm_cs;
  logic [4:0]   r_avm_addr;
  logic [31:0]  r_avm_wdata;

  logic         w_accept;
  logic         w_last_nonce;
  logic [3:0]   w_load_idx;
  logic         w_wr_en;
  logic [4:0]   w_wr_addr;
  logic [31:0]  w_wr_data;
  logic         w_cap_clear;
  logic         w_cap_enable;
  logic [255:0] w_hash;
  logic         w_marker_done;

  assign w_accept     = job_valid && job_ready;
  assign w_last_nonce = (r_nonce == r_nonce_end);
  assign w_load_idx   = r_word_cnt + 4'd1;

  hash_capture u_capture (
    .clk         (clk),
    .reset       (reset),
    .clear       (w_cap_clear),
    .enable      (w_cap_enable),
    .hash_idx    (acc.hash_idx),
    .hash_data   (acc.hash_data),
    .hash        (w_hash),
    .marker_done (w_marker_done)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_next = ST_LOAD;
      ST_LOAD:   if (r_word_cnt == 4'd15) w_state_next = ST_START;
      ST_NONCE:  w_state_next = ST_START;
      ST_START:  w_state_next = ST_WAIT;
      ST_WAIT:   if (w_marker_done) w_state_next = ST_ACK;
      ST_ACK:    w_state_next = ST_DRAIN;
      ST_DRAIN:  if (acc.hash_idx != IDX_DONE) w_state_next = r_hit ? ST_REPORT : ST_NEXT;
      ST_REPORT: if (res_ready) w_state_next = ST_NEXT;
      ST_NEXT:   w_state_next = w_last_nonce ? ST_IDLE : ST_NONCE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Output logic. The bus outputs are registered, so the write mux computes
  // the write that belongs to the state being entered at the next edge.
  always_comb begin
    job_ready    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    res_valid    = 1'b0;
    res_nonce    = '0;
    res_hash     = '0;
    w_wr_en      = 1'b0;
    w_wr_addr    = r_avm_addr;
    w_wr_data    = r_avm_wdata;
    w_cap_clear  = (r_state == ST_START);
    w_cap_enable = (r_state == ST_WAIT);

    // Status outputs are forced low for the whole reset cycle, not only
    // after the state register has been cleared.
    if (!reset) begin
      job_ready = (r_state == ST_IDLE);
      busy      = (r_state != ST_IDLE);
      done      = (r_state == ST_NEXT) && w_last_nonce;
      res_valid = (r_state == ST_REPORT);
      if (r_state == ST_REPORT) begin
        res_nonce = r_nonce;
        res_hash  = w_hash;
      end
    end

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_wr_en   = 1'b1;
          w_wr_addr = 5'd0;
          w_wr_data = (c_nonce_idx == 4'd0) ? job_nonce_start : job_block[31:0];
        end
      end
      ST_LOAD: begin
        w_wr_en = 1'b1;
        if (r_word_cnt == 4'd15) begin
          w_wr_addr = CTRL_ADDR;
          w_wr_data = CMD_START;
        end else begin
          w_wr_addr = {1'b0, w_load_idx};
          w_wr_data = (w_load_idx == c_nonce_idx) ? r_nonce
                                                  : r_block[{w_load_idx, 5'b00000} +: 32];
        end
      end
      ST_NONCE: begin
        w_wr_en   = 1'b1;
        w_wr_addr = CTRL_ADDR;
        w_wr_data = CMD_START;
      end
      ST_WAIT: begin
        if (w_marker_done) begin
          w_wr_en   = 1'b1;
          w_wr_addr = CTRL_ADDR;
          w_wr_data = CMD_ACK;
        end
      end
      ST_NEXT: begin
        if (!w_last_nonce) begin
          w_wr_en   = 1'b1;
          w_wr_addr = c_nonce_addr;
          w_wr_data = r_nonce + 32'd1;
        end
      end
      default: ;
    endcase
  end

  // Job latches: only meaningful after an accept, so no reset needed.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && w_accept) begin
      r_block     <= job_block;
      r_target    <= job_target;
      r_nonce_end <= job_nonce_end;
    end
  end

  // Nonce counter, LOAD word counter, compare result and bus registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_nonce     <= '0;
      r_word_cnt  <= '0;
      r_hit       <= 1'b0;
      r_avm_cs    <= 1'b0;
      r_avm_addr  <= '0;
      r_avm_wdata <= '0;
    end else begin
      r_avm_cs <= w_wr_en;
      if (w_wr_en) begin
        r_avm_addr  <= w_wr_addr;
        r_avm_wdata <= w_wr_data;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_nonce    <= job_nonce_start;
            r_word_cnt <= 4'd0;
          end
        end
        ST_LOAD: r_word_cnt <= r_word_cnt + 4'd1;
        ST_ACK:  r_hit <= (w_hash < r_target);
        ST_NEXT: if (!w_last_nonce) r_nonce <= r_nonce + 32'd1;
        default: ;
      endcase
    end
  end

  assign acc.avm_chipselect = r_avm_cs;
  assign acc.avm_write      = r_avm_cs;
  assign acc.avm_address    = r_avm_addr;
  assign acc.avm_writedata  = r_avm_wdata;

endmodule
`default_nettype wire
